// File: rtl/song_step_sequencer.sv
// song_step_sequencer
// Walks a song held in an external synchronous note ROM. Each entry is
// {half-period, duration}; the duration is counted in ticks of a slow
// divided clock that arrives as data on tickIn. A zero duration marks the
// end of the song and a zero period is a rest. All outputs are registered.

module song_step_sequencer #(
  parameter int PeriodBits   = 16,
  parameter int DurationBits = 12,
  parameter int AddrBits     = 5,
  parameter int SongLength   = 32
) (
  input  logic                               inputClock,
  input  logic                               reset_n,
  input  logic                               tickIn,
  input  logic                               start,
  input  logic                               stop,
  input  logic                               loopEnable,
  input  logic [PeriodBits+DurationBits-1:0] noteData,
  output logic [AddrBits-1:0]                noteAddr,
  output logic [PeriodBits-1:0]              tonePeriod,
  output logic                               toneEnable,
  output logic                               playing,
  output logic                               songDone
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_PLAY  = 2'd3
  } state_t;

  localparam logic [AddrBits-1:0]     LastAddr = AddrBits'(SongLength - 1);
  localparam logic [AddrBits-1:0]     AddrZero = {AddrBits{1'b0}};
  localparam logic [AddrBits-1:0]     AddrOne  = {{(AddrBits-1){1'b0}}, 1'b1};
  localparam logic [DurationBits-1:0] DurZero  = {DurationBits{1'b0}};
  localparam logic [DurationBits-1:0] DurOne   = {{(DurationBits-1){1'b0}}, 1'b1};
  localparam logic [PeriodBits-1:0]   PerZero  = {PeriodBits{1'b0}};

  // Registered state
  state_t                  r_state;
  logic                    r_sync1;
  logic                    r_sync2;
  logic                    r_sync3;
  logic                    r_tick;
  logic [DurationBits-1:0] r_count;
  logic [DurationBits-1:0] r_duration;
  logic [AddrBits-1:0]     r_noteAddr;
  logic [PeriodBits-1:0]   r_tonePeriod;
  logic                    r_toneEnable;
  logic                    r_playing;
  logic                    r_songDone;

  // Combinational next values
  state_t                  w_nextState;
  logic [DurationBits-1:0] w_nextCount;
  logic [DurationBits-1:0] w_nextDuration;
  logic [AddrBits-1:0]     w_nextAddr;
  logic [PeriodBits-1:0]   w_nextPeriod;
  logic                    w_nextTone;
  logic                    w_nextPlaying;
  logic                    w_nextDone;
  logic                    w_songEnd;
  logic                    w_edge;
  logic [PeriodBits-1:0]   w_romPeriod;
  logic [DurationBits-1:0] w_romDuration;

  assign w_romPeriod   = noteData[PeriodBits+DurationBits-1 -: PeriodBits];
  assign w_romDuration = noteData[DurationBits-1:0];

  // Rising edge of the synchronized tick; registered once more into r_tick.
  assign w_edge = r_sync2 & ~r_sync3;

  assign noteAddr   = r_noteAddr;
  assign tonePeriod = r_tonePeriod;
  assign toneEnable = r_toneEnable;
  assign playing    = r_playing;
  assign songDone   = r_songDone;

  // Synchronize tickIn and turn its rising edge into a one-cycle tick pulse.
  always_ff @(posedge inputClock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_sync1 <= tickIn;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_tick  <= w_edge;
    end
  end

  // Next-state and next-output decisions for the playback FSM.
  always_comb begin
    w_nextState    = r_state;
    w_nextCount    = r_count;
    w_nextDuration = r_duration;
    w_nextAddr     = r_noteAddr;
    w_nextPeriod   = r_tonePeriod;
    w_nextDone     = 1'b0;
    w_songEnd      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nextAddr  = AddrZero;
          w_nextState = ST_FETCH;
        end else begin
          w_nextState = ST_IDLE;
        end
      end

      ST_FETCH: begin
        // ROM data for the new address appears one cycle later.
        w_nextState = ST_LOAD;
      end

      ST_LOAD: begin
        if (w_romDuration == DurZero) begin
          // Zero duration is an end marker, not a note.
          w_songEnd = 1'b1;
        end else begin
          w_nextPeriod   = w_romPeriod;
          w_nextDuration = w_romDuration;
          w_nextCount    = DurZero;
          w_nextState    = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (r_tick) begin
          if (r_count == (r_duration - DurOne)) begin
            if (r_noteAddr == LastAddr) begin
              w_songEnd = 1'b1;
            end else begin
              w_nextAddr  = r_noteAddr + AddrOne;
              w_nextState = ST_FETCH;
            end
          end else begin
            w_nextCount = r_count + DurOne;
          end
        end else begin
          w_nextCount = r_count;
        end
      end

      default: begin
        w_nextState = ST_IDLE;
        w_nextAddr  = AddrZero;
        w_nextCount = DurZero;
      end
    endcase

    // End of song either wraps back to the first entry or finishes.
    if (w_songEnd) begin
      w_nextAddr = AddrZero;
      if (loopEnable) begin
        w_nextState = ST_FETCH;
      end else begin
        w_nextState = ST_IDLE;
        w_nextDone  = 1'b1;
      end
    end else begin
      w_nextDone = 1'b0;
    end

    // stop overrides everything, including a simultaneous start or song end.
    if (stop) begin
      w_nextState = ST_IDLE;
      w_nextAddr  = AddrZero;
      w_nextCount = DurZero;
      w_nextDone  = 1'b0;
    end else begin
      w_nextCount = w_nextCount;
    end

    // Outputs are derived from the state being entered so they register in step.
    w_nextTone    = (w_nextState == ST_PLAY) && (w_nextPeriod != PerZero);
    w_nextPlaying = (w_nextState != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge inputClock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_count      <= DurZero;
      r_duration   <= DurZero;
      r_noteAddr   <= AddrZero;
      r_tonePeriod <= PerZero;
      r_toneEnable <= 1'b0;
      r_playing    <= 1'b0;
      r_songDone   <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_count      <= w_nextCount;
      r_duration   <= w_nextDuration;
      r_noteAddr   <= w_nextAddr;
      r_tonePeriod <= w_nextPeriod;
      r_toneEnable <= w_nextTone;
      r_playing    <= w_nextPlaying;
      r_songDone   <= w_nextDone;
    end
  end

endmodule

// File: tb/tb_song_step_sequencer.sv
// Testbench for song_step_sequencer: a two-entry song instance (A) and a
// 32-entry song instance (B) share clock, reset and control inputs, each with
// its own synchronous ROM model.

module tb_song_step_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick_in = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;

  logic [27:0] data_a;
  logic [27:0] data_b;
  logic [4:0]  a_addr, b_addr;
  logic [15:0] a_period, b_period;
  logic        a_tone, b_tone, a_play, b_play, a_done, b_done;

  logic [27:0] rom_a [32];
  logic [27:0] rom_b [32];

  int checks = 0;
  int failures = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int snap;

  typedef struct {
    logic        start;
    logic        stop;
    logic        tick;
    int          n;
    logic [4:0]  addr;
    logic [15:0] period;
    logic        tone;
    logic        play;
    logic        done;
  } vec_t;

  vec_t vecs [15];

  always #5 clk = ~clk;

  song_step_sequencer #(.PeriodBits(16), .DurationBits(12), .AddrBits(5), .SongLength(2)) dut_a (
    .inputClock(clk), .reset_n(reset_n), .tickIn(tick_in), .start(start), .stop(stop),
    .loopEnable(loop_en), .noteData(data_a), .noteAddr(a_addr), .tonePeriod(a_period),
    .toneEnable(a_tone), .playing(a_play), .songDone(a_done)
  );

  song_step_sequencer #(.PeriodBits(16), .DurationBits(12), .AddrBits(5), .SongLength(32)) dut_b (
    .inputClock(clk), .reset_n(reset_n), .tickIn(tick_in), .start(start), .stop(stop),
    .loopEnable(loop_en), .noteData(data_b), .noteAddr(b_addr), .tonePeriod(b_period),
    .toneEnable(b_tone), .playing(b_play), .songDone(b_done)
  );

  // Synchronous ROM models: data valid the cycle after the address changes.
  always @(posedge clk) begin
    data_a <= rom_a[a_addr];
    data_b <= rom_b[b_addr];
  end

  // Count songDone pulses seen on each instance.
  always @(posedge clk) begin
    if (a_done) done_cnt_a <= done_cnt_a + 1;
    if (b_done) done_cnt_b <= done_cnt_b + 1;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_a(input string name, input logic [4:0] addr, input logic [15:0] per,
                         input logic tone, input logic play, input logic done);
    check({name, ".addr"}, 32'(a_addr), 32'(addr));
    check({name, ".period"}, 32'(a_period), 32'(per));
    check({name, ".tone"}, 32'(a_tone), 32'(tone));
    check({name, ".playing"}, 32'(a_play), 32'(play));
    check({name, ".done"}, 32'(a_done), 32'(done));
  endtask

  task automatic do_reset();
    start = 1'b0;
    stop = 1'b0;
    tick_in = 1'b0;
    reset_n = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  // One tickIn period: high 2 cycles, low 4; the tick is acted on 3 edges after the rise.
  task automatic tick_pulse();
    tick_in = 1'b1;
    cycles(2);
    tick_in = 1'b0;
    cycles(4);
  endtask

  initial begin
    //          start stop tick n  addr   period     tone play done
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1, 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 2, 5'd0, 16'h0100, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 2, 5'd0, 16'h0100, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4, 5'd0, 16'h0100, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 2, 5'd0, 16'h0100, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4, 5'd0, 16'h0100, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 2, 5'd0, 16'h0100, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 2, 5'd1, 16'h0100, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1, 5'd1, 16'h0100, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1, 5'd1, 16'h0200, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 2, 5'd1, 16'h0200, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 4, 5'd1, 16'h0200, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 2, 5'd1, 16'h0200, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 2, 5'd0, 16'h0200, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1, 5'd0, 16'h0200, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 32; i++) begin
      rom_a[i] = {16'h0000, 12'd0};
      rom_b[i] = {16'(16'h0010 + i), 12'd1};
    end

    // Reset state and basic two-note playback, table driven.
    rom_a[0] = {16'h0100, 12'd3};
    rom_a[1] = {16'h0200, 12'd2};
    loop_en = 1'b0;
    do_reset();
    check_a("reset", 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    snap = done_cnt_a;
    for (int i = 0; i < 15; i++) begin
      start = vecs[i].start;
      stop = vecs[i].stop;
      tick_in = vecs[i].tick;
      cycles(vecs[i].n);
      check_a($sformatf("vec%0d", i), vecs[i].addr, vecs[i].period,
              vecs[i].tone, vecs[i].play, vecs[i].done);
    end
    cycles(1);
    check("basic.done_count", 32'(done_cnt_a - snap), 32'd1);

    // Rest: silent but playing for four ticks, then next address.
    rom_a[0] = {16'h0000, 12'd4};
    rom_a[1] = {16'h0300, 12'd2};
    do_reset();
    pulse_start();
    cycles(2);
    check_a("rest.enter", 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
    for (int t = 1; t <= 3; t++) begin
      tick_pulse();
      check_a($sformatf("rest.tick%0d", t), 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
    end
    tick_pulse();
    check_a("rest.next", 5'd1, 16'h0300, 1'b1, 1'b1, 1'b0);

    // End marker with loop: wraps to address 0 without songDone.
    rom_a[0] = {16'h0100, 12'd1};
    rom_a[1] = {16'h0777, 12'd0};
    loop_en = 1'b1;
    do_reset();
    snap = done_cnt_a;
    pulse_start();
    cycles(2);
    check_a("endloop.play0", 5'd0, 16'h0100, 1'b1, 1'b1, 1'b0);
    tick_pulse();
    check_a("endloop.wrap", 5'd0, 16'h0100, 1'b0, 1'b1, 1'b0);
    cycles(2);
    check_a("endloop.replay", 5'd0, 16'h0100, 1'b1, 1'b1, 1'b0);
    cycles(1);
    check("endloop.no_done", 32'(done_cnt_a - snap), 32'd0);

    // End marker without loop: songDone right after LOAD of address 1.
    loop_en = 1'b0;
    do_reset();
    snap = done_cnt_a;
    pulse_start();
    cycles(2);
    tick_pulse();
    check_a("endstop.done", 5'd0, 16'h0100, 1'b0, 1'b0, 1'b1);
    cycles(1);
    check_a("endstop.after", 5'd0, 16'h0100, 1'b0, 1'b0, 1'b0);
    check("endstop.done_count", 32'(done_cnt_a - snap), 32'd1);

    // Stop during the second tick of a five-tick note.
    rom_a[0] = {16'h0400, 12'd5};
    rom_a[1] = {16'h0500, 12'd1};
    do_reset();
    snap = done_cnt_a;
    pulse_start();
    cycles(2);
    tick_pulse();
    tick_in = 1'b1;
    cycles(2);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    tick_in = 1'b0;
    check_a("stop.idle", 5'd0, 16'h0400, 1'b0, 1'b0, 1'b0);
    cycles(4);
    check_a("stop.hold", 5'd0, 16'h0400, 1'b0, 1'b0, 1'b0);
    check("stop.no_done", 32'(done_cnt_a - snap), 32'd0);

    // Simultaneous start and stop in IDLE stays IDLE.
    start = 1'b1;
    stop = 1'b1;
    cycles(1);
    start = 1'b0;
    stop = 1'b0;
    check_a("startstop.1", 5'd0, 16'h0400, 1'b0, 1'b0, 1'b0);
    cycles(2);
    check_a("startstop.3", 5'd0, 16'h0400, 1'b0, 1'b0, 1'b0);

    // start during PLAY of address 1 is ignored.
    rom_a[0] = {16'h0100, 12'd3};
    rom_a[1] = {16'h0200, 12'd2};
    do_reset();
    pulse_start();
    cycles(2);
    for (int t = 0; t < 3; t++) tick_pulse();
    check_a("restart.before", 5'd1, 16'h0200, 1'b1, 1'b1, 1'b0);
    pulse_start();
    check_a("restart.pulse", 5'd1, 16'h0200, 1'b1, 1'b1, 1'b0);
    cycles(2);
    check_a("restart.after", 5'd1, 16'h0200, 1'b1, 1'b1, 1'b0);

    // 32-entry song, all durations 1, loop on: address 31 wraps to 0.
    loop_en = 1'b1;
    do_reset();
    snap = done_cnt_b;
    pulse_start();
    cycles(2);
    check("wrap.addr0", 32'(b_addr), 32'd0);
    check("wrap.tone0", 32'(b_tone), 32'd1);
    for (int t = 1; t < 32; t++) begin
      tick_pulse();
      check($sformatf("wrap.addr%0d", t), 32'(b_addr), 32'(t));
      check($sformatf("wrap.period%0d", t), 32'(b_period), 32'(16'h0010 + t));
    end
    tick_pulse();
    check("wrap.addr_back", 32'(b_addr), 32'd0);
    check("wrap.period_back", 32'(b_period), 32'h0010);
    check("wrap.playing", 32'(b_play), 32'd1);
    check("wrap.no_done", 32'(done_cnt_b - snap), 32'd0);

    // Asynchronous reset mid-PLAY, checked between clock edges.
    tick_pulse();
    tick_pulse();
    check("areset.pre_addr", 32'(b_addr), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset.addr", 32'(b_addr), 32'd0);
    check("areset.period", 32'(b_period), 32'd0);
    check("areset.tone", 32'(b_tone), 32'd0);
    check("areset.playing", 32'(b_play), 32'd0);
    check("areset.done", 32'(b_done), 32'd0);
    cycles(1);
    reset_n = 1'b1;
    cycles(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
